// File: rtl/scan_chain_ctrl.sv
// Scan-chain controller: shifts a pattern into an external scan chain, optionally
// fires one capture edge, unloads the chain via SO and compares against a reference.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 16,
   parameter int CNT_W     = 5,
   parameter int ERR_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 clk_i,
   input  logic                 rstb_i,
   input  logic                 start_i,
   input  logic                 mode_i,
   input  logic [CHAIN_LEN-1:0] pat_in_i,
   input  logic [CHAIN_LEN-1:0] exp_in_i,
   input  logic                 so_i,
   output logic                 se_o,
   output logic                 si_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [CHAIN_LEN-1:0] cap_out_o,
   output logic [ERR_W-1:0]     err_cnt_o
);

   // state     | meaning
   // IDLE      | waiting for start_i; SE=SI=0
   // SHIFT_IN  | one edge per pattern bit with SE=1, MSB first
   // CAPTURE   | single functional edge with SE=0 (capture mode only)
   // SHIFT_OUT | one edge per cell with SE=1, SI=0, sampling SO
   // CHECK     | compare unloaded vector, pulse DONE
   typedef enum logic [2:0] {
      IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, CHECK
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHAIN_LEN - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] cap_q, cap_d;
   logic [CHAIN_LEN-1:0] pat_q, pat_d;
   logic [CHAIN_LEN-1:0] exp_q, exp_d;
   logic                 mode_q, mode_d;
   logic                 se_q, se_d;
   logic                 si_q, si_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [CHAIN_LEN-1:0] cap_out_q, cap_out_d;
   logic [ERR_W-1:0]     err_q, err_d;

   logic [CHAIN_LEN-1:0] diff;
   logic [ERR_W-1:0]     err_sum;

   always_comb begin
      diff    = cap_q ^ (mode_q ? pat_q : exp_q);
      err_sum = '0;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         err_sum = err_sum + ERR_W'(diff[i]);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      pat_d     = pat_q;
      exp_d     = exp_q;
      mode_d    = mode_q;
      se_d      = 1'b0;
      si_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      cap_out_d = cap_out_q;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               pat_d   = pat_in_i;
               exp_d   = exp_in_i;
               mode_d  = mode_i;
               // cap_q doubles as the shift-in source; its MSB feeds the next SI
               cap_d   = {pat_in_i[CHAIN_LEN-2:0], 1'b0};
               si_d    = pat_in_i[CHAIN_LEN-1];
               se_d    = 1'b1;
               cnt_d   = CNT_LOAD;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               state_d = SHIFT_IN;
            end
         end
         SHIFT_IN: begin
            if (cnt_q != '0) begin
               se_d  = 1'b1;
               si_d  = cap_q[CHAIN_LEN-1];
               cap_d = {cap_q[CHAIN_LEN-2:0], 1'b0};
               cnt_d = cnt_q - CNT_W'(1);
            end else if (mode_q) begin
               se_d    = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = SHIFT_OUT;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            se_d    = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = SHIFT_OUT;
         end
         SHIFT_OUT: begin
            cap_d = {cap_q[CHAIN_LEN-2:0], so_i};
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               se_d  = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CHECK: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            cap_out_d = cap_q;
            err_d     = err_sum;
            pass_d    = (err_sum == '0);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstb_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cap_q     <= '0;
         pat_q     <= '0;
         exp_q     <= '0;
         mode_q    <= 1'b0;
         se_q      <= 1'b0;
         si_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         cap_out_q <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         pat_q     <= pat_d;
         exp_q     <= exp_d;
         mode_q    <= mode_d;
         se_q      <= se_d;
         si_q      <= si_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         cap_out_q <= cap_out_d;
         err_q     <= err_d;
      end
   end

   assign se_o      = se_q;
   assign si_o      = si_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign pass_o    = pass_q;
   assign cap_out_o = cap_out_q;
   assign err_cnt_o = err_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-cell behavioural scan chain
// (plain D=Q or inverting D=~Q capture, optional SO stuck-at-0).
module tb_scan_chain_ctrl;

   localparam int N = 4;
   localparam int EW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rstb;
   logic          start;
   logic          mode;
   logic [N-1:0]  pat_in;
   logic [N-1:0]  exp_in;
   logic          so;
   logic          se;
   logic          si;
   logic          busy;
   logic          done;
   logic          pass;
   logic [N-1:0]  cap_out;
   logic [EW-1:0] err_cnt;

   logic [N-1:0]  chain = '0;
   logic          inv_cap = 1'b0;
   logic          so_stuck = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(5)) dut (
      .clk_i     (clk),
      .rstb_i    (rstb),
      .start_i   (start),
      .mode_i    (mode),
      .pat_in_i  (pat_in),
      .exp_in_i  (exp_in),
      .so_i      (so),
      .se_o      (se),
      .si_o      (si),
      .busy_o    (busy),
      .done_o    (done),
      .pass_o    (pass),
      .cap_out_o (cap_out),
      .err_cnt_o (err_cnt)
   );

   always @(posedge clk) begin
      if (se) chain <= {chain[N-2:0], si};
      else if (inv_cap) chain <= ~chain;
   end

   assign so = so_stuck ? 1'b0 : chain[N-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", tag, got, want);
   endtask

   // Runs one operation for a fixed budget of 25 edges after t0.
   task automatic run_op(input logic md, input logic [N-1:0] pat, input logic [N-1:0] ex,
                         input int restart_at, input int rst_at,
                         output int done_edge, output int done_num,
                         output logic [31:0] se_mask, output logic [31:0] snap);
      done_edge = -1;
      done_num  = 0;
      se_mask   = '0;
      snap      = 32'hffff_ffff;
      @(negedge clk);
      mode   = md;
      pat_in = pat;
      exp_in = ex;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         rstb  = (k != rst_at);
         se_mask[k] = se;
         @(posedge clk);
         #1;
         if (done) begin
            done_num++;
            if (done_edge < 0) done_edge = k;
         end
         if (k == rst_at)
            snap = {16'h0, se, si, busy, done, pass, cap_out, err_cnt};
      end
   endtask

   int          de, dn;
   logic [31:0] sm, sn;

   initial begin
      rstb = 1'b0; start = 1'b0; mode = 1'b0; pat_in = '0; exp_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {se, si, busy, done, pass, cap_out, err_cnt}, 0);
      @(negedge clk) rstb = 1'b1;

      // 1: flush, plain chain
      inv_cap = 1'b0;
      run_op(1'b1, 4'b1011, 4'b0000, 0, 0, de, dn, sm, sn);
      chk("t1_done_edge", de, 9);
      chk("t1_se_mask", sm[9:1], 9'b0_1111_1111);
      chk("t1_cap", cap_out, 4'b1011);
      chk("t1_pass", pass, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_busy_end", busy, 0);

      // 2: capture, inverting chain
      inv_cap = 1'b1;
      run_op(1'b0, 4'b1011, 4'b0100, 0, 0, de, dn, sm, sn);
      chk("t2_done_edge", de, 10);
      chk("t2_se_mask", sm[10:1], 10'b01_1110_1111);
      chk("t2_cap", cap_out, 4'b0100);
      chk("t2_pass", pass, 1);
      chk("t2_done_num", dn, 1);

      // 3: capture with wrong expectation
      run_op(1'b0, 4'b1011, 4'b0111, 0, 0, de, dn, sm, sn);
      chk("t3_done_edge", de, 10);
      chk("t3_cap", cap_out, 4'b0100);
      chk("t3_err", err_cnt, 2);
      chk("t3_pass", pass, 0);

      // 4: SO stuck-at-0, flush
      inv_cap = 1'b0;
      so_stuck = 1'b1;
      run_op(1'b1, 4'b1111, 4'b0000, 0, 0, de, dn, sm, sn);
      chk("t4_done_edge", de, 9);
      chk("t4_cap", cap_out, 4'b0000);
      chk("t4_err", err_cnt, 4);
      chk("t4_pass", pass, 0);
      so_stuck = 1'b0;

      // 5: START re-pulsed during shift-in
      run_op(1'b1, 4'b0110, 4'b0000, 3, 0, de, dn, sm, sn);
      chk("t5_done_num", dn, 1);
      chk("t5_done_edge", de, 9);
      chk("t5_cap", cap_out, 4'b0110);
      chk("t5_pass", pass, 1);

      // 6: reset mid-operation, then a clean run
      inv_cap = 1'b1;
      run_op(1'b0, 4'b1011, 4'b0100, 0, 6, de, dn, sm, sn);
      chk("t6_rst_snap", sn, 0);
      chk("t6_done_num", dn, 0);
      chk("t6_busy_idle", busy, 0);
      run_op(1'b0, 4'b0011, 4'b1100, 0, 0, de, dn, sm, sn);
      chk("t6b_done_edge", de, 10);
      chk("t6b_cap", cap_out, 4'b1100);
      chk("t6b_pass", pass, 1);
      chk("t6b_err", err_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
